// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and slave FSM state type
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        SLV_IDLE   = 2'd0,
        SLV_SETUP  = 2'd1,
        SLV_ACCESS = 2'd2
    } apb_slv_state_t;

endpackage

// File: rtl/apb_mem_slave_if.sv
// rtl/apb_mem_slave_if.sv - APB bus bundle between master and memory slave
// Signals: psel, penable, pwrite, paddr, pw_data (master -> slave);
//          pready, pr_data, and pslverr when APB_SLVERR_EN is defined (slave -> master).
interface apb_mem_slave_if;
    import apb_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pw_data;
    logic                  pready;
    logic [APB_DATA_W-1:0] pr_data;
`ifdef APB_SLVERR_EN
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pw_data,
        input  pready, pr_data, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pw_data,
        output pready, pr_data, pslverr
    );
`else
    modport master (
        output psel, penable, pwrite, paddr, pw_data,
        input  pready, pr_data
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pw_data,
        output pready, pr_data
    );
`endif

endinterface

// File: rtl/apb_slave_ram.sv
// rtl/apb_slave_ram.sv - DEPTH x 8 storage, one write port, one combinational read port
// Ports: pclk, presetn (async clear of all locations), we/waddr/wdata (write),
//        raddr/rdata (combinational read).
module apb_slave_ram
    import apb_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB byte-memory slave with programmable wait states
// Ports: pclk, presetn (async active-low), bus (apb_mem_slave_if.slave:
//        psel, penable, pwrite, paddr, pw_data, pready, pr_data[, pslverr]).
// Optional: APB_SLVERR_EN adds pslverr and rejects addresses >= DEPTH.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_mem_slave_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    apb_slv_state_t        state;
    logic [3:0]            wait_cnt;
    logic [APB_ADDR_W-1:0] addr_q;
    logic                  write_q;
    logic [APB_DATA_W-1:0] data_q;

    logic                  pready_int;
    logic                  complete;
    logic                  in_range;
    logic                  ram_we;
    logic [APB_DATA_W-1:0] ram_rdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= SLV_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state)
                SLV_IDLE: begin
                    // An access phase with no preceding setup is not a transfer.
                    if (bus.psel && !bus.penable) begin
                        state <= SLV_SETUP;
                    end
                end
                SLV_SETUP: begin
                    if (!bus.psel) begin
                        state <= SLV_IDLE;
                    end else begin
                        addr_q   <= bus.paddr;
                        write_q  <= bus.pwrite;
                        data_q   <= bus.pw_data;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= SLV_ACCESS;
                    end
                end
                SLV_ACCESS: begin
                    if (!bus.psel) begin
                        state <= SLV_IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (bus.penable) begin
                        state <= SLV_IDLE;
                    end
                end
                default: state <= SLV_IDLE;
            endcase
        end
    end

    assign pready_int = (state == SLV_ACCESS) && (wait_cnt == 4'd0);
    assign complete   = pready_int && bus.psel && bus.penable;

`ifdef APB_SLVERR_EN
    assign in_range    = (int'(addr_q) < DEPTH);
    assign bus.pslverr = pready_int && !in_range;
`else
    // Upper address bits are dropped by the RAM index, so every address wraps.
    assign in_range    = 1'b1;
`endif

    assign ram_we = complete && write_q && in_range;

    apb_slave_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (ram_we),
        .waddr   (addr_q[AW-1:0]),
        .wdata   (data_q),
        .raddr   (addr_q[AW-1:0]),
        .rdata   (ram_rdata)
    );

    assign bus.pready  = pready_int;
    assign bus.pr_data = (pready_int && !write_q && in_range) ? ram_rdata : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - directed bench for apb_mem_slave (default, WAIT_CYCLES=0, DEPTH=16 instances)
module tb_apb_mem_slave;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pw_data;

    int vectors    = 0;
    int miscompares = 0;

    // Per-instance transfer observations: 0 = default, 1 = WAIT_CYCLES=0, 2 = DEPTH=16.
    int         rdy_at  [3];
    int         rdy_cnt [3];
    logic [7:0] rd      [3];
    logic       err_seen;
    logic       spurious;

    always #5 pclk = ~pclk;

    apb_mem_slave_if bus_m ();
    apb_mem_slave_if bus_w ();
    apb_mem_slave_if bus_d ();

    assign bus_m.psel = psel;  assign bus_m.penable = penable;  assign bus_m.pwrite = pwrite;
    assign bus_m.paddr = paddr; assign bus_m.pw_data = pw_data;
    assign bus_w.psel = psel;  assign bus_w.penable = penable;  assign bus_w.pwrite = pwrite;
    assign bus_w.paddr = paddr; assign bus_w.pw_data = pw_data;
    assign bus_d.psel = psel;  assign bus_d.penable = penable;  assign bus_d.pwrite = pwrite;
    assign bus_d.paddr = paddr; assign bus_d.pw_data = pw_data;

    apb_mem_slave #(.DEPTH(256), .WAIT_CYCLES(2)) dut_m (.pclk(pclk), .presetn(presetn), .bus(bus_m));
    apb_mem_slave #(.DEPTH(256), .WAIT_CYCLES(0)) dut_w (.pclk(pclk), .presetn(presetn), .bus(bus_w));
    apb_mem_slave #(.DEPTH(16),  .WAIT_CYCLES(2)) dut_d (.pclk(pclk), .presetn(presetn), .bus(bus_d));

    logic [2:0] rdy_v;
    logic [7:0] prd_v [3];
    assign rdy_v    = {bus_d.pready, bus_w.pready, bus_m.pready};
    assign prd_v[0] = bus_m.pr_data;
    assign prd_v[1] = bus_w.pr_data;
    assign prd_v[2] = bus_d.pr_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) tick();
    endtask

    task automatic sample(input int k);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rdy_v[i]) begin
                rdy_cnt[i]++;
                rdy_at[i] = k;
                rd[i]     = prd_v[i];
            end else if (prd_v[i] !== 8'h00) begin
                spurious = 1'b1;
            end
        end
`ifdef APB_SLVERR_EN
        if (bus_d.pslverr && !bus_d.pready) spurious = 1'b1;
        if (bus_d.pslverr && bus_d.pready)  err_seen = 1'b1;
`endif
    endtask

    // One setup cycle, then n_acc access-phase cycles; the bus is left selected afterwards.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int n_acc, input bit scramble);
        for (int i = 0; i < 3; i++) begin
            rdy_at[i]  = -1;
            rdy_cnt[i] = 0;
            rd[i]      = 8'h00;
        end
        err_seen = 1'b0;
        spurious = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pw_data = d;
        sample(-1);
        tick();
        for (int k = 0; k < n_acc; k++) begin
            penable = 1'b1;
            if (scramble && k > 0) begin
                paddr   = ~a;
                pw_data = ~d;
                pwrite  = ~wr;
            end
            sample(k);
            tick();
        end
    endtask

    initial begin
        presetn = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00; pw_data = 8'h00;
        repeat (2) @(posedge pclk);
        #3;
        chk("rst_pready_m", 32'(bus_m.pready), 32'd0);
        chk("rst_pready_w", 32'(bus_w.pready), 32'd0);
        chk("rst_pready_d", 32'(bus_d.pready), 32'd0);
        chk("rst_prdata_m", 32'(bus_m.pr_data), 32'h00);
        presetn = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            if (rdy_v != 3'b000) spurious = 1'b1;
        end
        chk("rst_hold_no_pready", 32'(spurious), 32'd0);
        idle(1);

        xfer(1'b0, 8'h05, 8'h00, 4, 1'b0);
        chk("w0_rd05_rdy_at",  32'(rdy_at[1]),  32'd1);
        chk("w0_rd05_rdy_cnt", 32'(rdy_cnt[1]), 32'd1);
        chk("w0_rd05_data",    32'(rd[1]),      32'h00);
        chk("m_rd05_rdy_at",   32'(rdy_at[0]),  32'd3);
        chk("rd05_spurious",   32'(spurious),   32'd0);

        xfer(1'b1, 8'h12, 8'h3C, 4, 1'b1);
        chk("m_wr12_rdy_at",  32'(rdy_at[0]),  32'd3);
        chk("m_wr12_rdy_cnt", 32'(rdy_cnt[0]), 32'd1);
        chk("m_wr12_prdata",  32'(rd[0]),      32'h00);
        chk("d_wr12_rdy_at",  32'(rdy_at[2]),  32'd3);
`ifdef APB_SLVERR_EN
        chk("d_wr12_slverr",  32'(err_seen),   32'd1);
`endif
        xfer(1'b0, 8'h12, 8'h00, 4, 1'b0);
        chk("m_rd12_data",    32'(rd[0]),      32'h3C);
        chk("m_rd12_rdy_at",  32'(rdy_at[0]),  32'd3);
        chk("w0_rd12_data",   32'(rd[1]),      32'h3C);
        chk("rd12_spurious",  32'(spurious),   32'd0);

        xfer(1'b1, 8'h20, 8'hAA, 2, 1'b0);
        idle(1);
        chk("m_abort_no_pready", 32'(rdy_cnt[0]), 32'd0);
        xfer(1'b0, 8'h20, 8'h00, 4, 1'b0);
        chk("m_rd20_data",       32'(rd[0]),      32'h00);
        chk("m_rd20_rdy_cnt",    32'(rdy_cnt[0]), 32'd1);

        xfer(1'b1, 8'h00, 8'h01, 4, 1'b0);
        chk("m_b2b_wr0_cnt", 32'(rdy_cnt[0]), 32'd1);
        xfer(1'b1, 8'h01, 8'h02, 4, 1'b0);
        chk("m_b2b_wr1_cnt", 32'(rdy_cnt[0]), 32'd1);
        xfer(1'b0, 8'h00, 8'h00, 4, 1'b0);
        chk("m_b2b_rd0_data", 32'(rd[0]),      32'h01);
        chk("m_b2b_rd0_cnt",  32'(rdy_cnt[0]), 32'd1);
        xfer(1'b0, 8'h01, 8'h00, 4, 1'b0);
        chk("m_b2b_rd1_data", 32'(rd[0]),      32'h02);
        chk("d_b2b_rd1_data", 32'(rd[2]),      32'h02);

        xfer(1'b1, 8'h13, 8'h77, 4, 1'b0);
        chk("d_wr13_rdy_cnt", 32'(rdy_cnt[2]), 32'd1);
`ifdef APB_SLVERR_EN
        chk("d_wr13_slverr",  32'(err_seen),   32'd1);
`endif
        xfer(1'b0, 8'h03, 8'h00, 4, 1'b0);
`ifdef APB_SLVERR_EN
        chk("d_rd03_data",    32'(rd[2]),      32'h00);
        chk("d_rd03_slverr",  32'(err_seen),   32'd0);
`else
        chk("d_rd03_data",    32'(rd[2]),      32'h77);
`endif
        chk("m_rd03_data",    32'(rd[0]),      32'h00);
        chk("rd03_spurious",  32'(spurious),   32'd0);

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pw_data = 8'h99;
        tick();
        penable = 1'b1;
        tick();
        presetn = 1'b0;
        #1;
        chk("midrst_pready_m", 32'(bus_m.pready), 32'd0);
        tick();
        presetn = 1'b1;
        idle(1);
        xfer(1'b0, 8'h01, 8'h00, 4, 1'b0);
        chk("midrst_rd01_data", 32'(rd[0]),      32'h00);
        chk("midrst_rd01_cnt",  32'(rdy_cnt[0]), 32'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
